core_bus_arbiter: RTL and testbench

Shares one Wishbone classic master port between the core's instruction-fetch port and its MEM-stage data port. It sequences up to two bus transfers per pipeline step, with data first and fetch second. It also generates the `stall_pipl` signal that freezes the pipeline until both transfers finish. It handles byte-lane generation, load alignment and sign extension, misalignment detection and bus timeout.

---
 rtl/core_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 tb/tb_core_bus_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_arbiter.sv
// Arbitrates one Wishbone classic master between the MEM-stage data port and the fetch port.
// Data is served first and fetch second. stall_pipl holds the pipeline until both transfers finish.
module core_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_op,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        stall_pipl,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_FETCH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYCLES);

  function automatic logic misalign(input logic [2:0] op, input logic [1:0] a);
    case (op[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = a[0];
      default: misalign = (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [2:0] op, input logic [1:0] a);
    case (op[1:0])
      2'b00:   lane_sel = 4'b0001 << a;
      2'b01:   lane_sel = 4'b0011 << {a[1], 1'b0};
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_dat(input logic [2:0] op, input logic [31:0] w);
    case (op[1:0])
      2'b00:   lane_dat = {4{w[7:0]}};
      2'b01:   lane_dat = {2{w[15:0]}};
      default: lane_dat = w;
    endcase
  endfunction

  // Shift the addressed lane down, then sign- or zero-extend by op[2].
  function automatic logic [31:0] ld_extract(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] data);
    logic [31:0] sh;
    sh = data >> {a, 3'b000};
    case (op[1:0])
      2'b00:   ld_extract = op[2] ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   ld_extract = op[2] ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: ld_extract = sh;
    endcase
  endfunction

  state_t      state_r, state_nxt_s;
  logic [7:0]  tmo_r;
  logic [31:0] d_addr_r;
  logic [2:0]  d_op_r;
  logic        d_we_r;
  logic [31:2] i_addr_r;
  logic        i_pend_r;
  logic        cyc_nxt_s, stb_nxt_s, we_nxt_s;
  logic [31:0] adr_nxt_s, dat_nxt_s;
  logic [3:0]  sel_nxt_s;
  logic        tmo_hit_s, term_s, bus_err_s, d_mis_s, unused_ok_s;

  assign unused_ok_s = &{1'b0, i_addr[1:0]};
  assign tmo_hit_s   = (tmo_r == TMO_LIM);
  assign term_s      = wb_ack_i | wb_err_i | tmo_hit_s;
  assign bus_err_s   = wb_err_i | (tmo_hit_s & ~wb_ack_i);
  assign d_mis_s     = d_req & misalign(d_op, d_addr[1:0]);

  // Pipeline freeze, combinational from state and live requests
  always_comb begin
    if ((state_r == S_DATA) || (state_r == S_FETCH)) begin
      stall_pipl = 1'b1;
    end else if (state_r == S_IDLE) begin
      stall_pipl = i_req | d_req;
    end else begin
      stall_pipl = 1'b0;
    end
  end

  // Next-state and next bus values; bus registers hold unless a transfer starts or ends
  always_comb begin
    state_nxt_s = state_r;
    cyc_nxt_s   = wb_cyc_o;
    stb_nxt_s   = wb_stb_o;
    we_nxt_s    = wb_we_o;
    adr_nxt_s   = wb_adr_o;
    sel_nxt_s   = wb_sel_o;
    dat_nxt_s   = wb_dat_o;
    case (state_r)
      S_IDLE: begin
        if (d_req && !d_mis_s) begin
          state_nxt_s = S_DATA;
          cyc_nxt_s   = 1'b1;
          stb_nxt_s   = 1'b1;
          we_nxt_s    = d_we;
          adr_nxt_s   = {d_addr[31:2], 2'b00};
          sel_nxt_s   = lane_sel(d_op, d_addr[1:0]);
          dat_nxt_s   = lane_dat(d_op, d_wdata);
        end else if (i_req) begin
          state_nxt_s = S_FETCH;
          cyc_nxt_s   = 1'b1;
          stb_nxt_s   = 1'b1;
          we_nxt_s    = 1'b0;
          adr_nxt_s   = {i_addr[31:2], 2'b00};
          sel_nxt_s   = 4'b1111;
          dat_nxt_s   = 32'h0000_0000;
        end else if (d_req) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_DATA: begin
        if (term_s && i_pend_r) begin
          state_nxt_s = S_FETCH;
          we_nxt_s    = 1'b0;
          adr_nxt_s   = {i_addr_r, 2'b00};
          sel_nxt_s   = 4'b1111;
          dat_nxt_s   = 32'h0000_0000;
        end else if (term_s) begin
          state_nxt_s = S_DONE;
          cyc_nxt_s   = 1'b0;
          stb_nxt_s   = 1'b0;
          we_nxt_s    = 1'b0;
          adr_nxt_s   = 32'h0000_0000;
          sel_nxt_s   = 4'b0000;
          dat_nxt_s   = 32'h0000_0000;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_FETCH: begin
        if (term_s) begin
          state_nxt_s = S_DONE;
          cyc_nxt_s   = 1'b0;
          stb_nxt_s   = 1'b0;
          we_nxt_s    = 1'b0;
          adr_nxt_s   = 32'h0000_0000;
          sel_nxt_s   = 4'b0000;
          dat_nxt_s   = 32'h0000_0000;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, bus registers and request latches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= S_IDLE;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= 32'h0000_0000;
      wb_sel_o <= 4'b0000;
      wb_dat_o <= 32'h0000_0000;
      d_addr_r <= 32'h0000_0000;
      d_op_r   <= 3'b000;
      d_we_r   <= 1'b0;
      i_addr_r <= 30'h0000_0000;
      i_pend_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      wb_cyc_o <= cyc_nxt_s;
      wb_stb_o <= stb_nxt_s;
      wb_we_o  <= we_nxt_s;
      wb_adr_o <= adr_nxt_s;
      wb_sel_o <= sel_nxt_s;
      wb_dat_o <= dat_nxt_s;
      if ((state_r == S_IDLE) && (d_req || i_req)) begin
        d_addr_r <= d_addr;
        d_op_r   <= d_op;
        d_we_r   <= d_we;
        i_addr_r <= i_addr[31:2];
        i_pend_r <= i_req;
      end
    end
  end

  // Wait-state counter, cleared whenever no transfer is in progress or one terminates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_r <= 8'd0;
    end else if (((state_r == S_DATA) || (state_r == S_FETCH)) && !term_s) begin
      tmo_r <= tmo_r + 8'd1;
    end else begin
      tmo_r <= 8'd0;
    end
  end

  // Result registers: captured at termination; error flags drop on leaving DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_rdata <= 32'h0000_0000;
      d_err   <= 1'b0;
      i_rdata <= 32'h0000_0000;
      i_err   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (d_mis_s) begin
            d_rdata <= 32'h0000_0000;
            d_err   <= 1'b1;
          end
        end
        S_DATA: begin
          if (term_s) begin
            d_err   <= bus_err_s;
            d_rdata <= (bus_err_s || d_we_r) ? 32'h0000_0000
                                             : ld_extract(d_op_r, d_addr_r[1:0], wb_dat_i);
          end
        end
        S_FETCH: begin
          if (term_s) begin
            i_err   <= bus_err_s;
            i_rdata <= bus_err_s ? 32'h0000_0000 : wb_dat_i;
          end
        end
        S_DONE: begin
          d_err <= 1'b0;
          i_err <= 1'b0;
        end
        default: begin
          d_err <= 1'b0;
          i_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter with a tiny zero-wait slave whose ack/err can be gated.
module tb_core_bus_arbiter;
  logic        clk, reset_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [2:0]  d_op;
  logic [31:0] i_rdata, d_rdata;
  logic        i_err, d_err, stall_pipl;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;

  int checks, failures;
  logic        ack_en, err_en;
  logic [31:0] fetch_adr, fetch_dat, load_dat;
  int          stall_cyc, stb_cyc, cyc_cyc, data_phase;
  bit          done_seen;
  logic [3:0]  data_sel;
  logic [31:0] data_dat;
  logic        data_we;

  core_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_err(d_err), .stall_pipl(stall_pipl),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  assign wb_err_i = wb_stb_o & err_en & (wb_adr_o != fetch_adr);
  assign wb_ack_i = wb_stb_o & ack_en & ~wb_err_i;
  assign wb_dat_i = (wb_adr_o == fetch_adr) ? fetch_dat : load_dat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs the current request set until stall_pipl drops (DONE), recording bus activity.
  task automatic run_until_done(input int limit);
    #1;
    stall_cyc = 0; stb_cyc = 0; cyc_cyc = 0; data_phase = 0; done_seen = 1'b0;
    data_sel = 4'b0000; data_dat = 32'h0; data_we = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (!stall_pipl) begin
        done_seen = 1'b1;
        break;
      end
      stall_cyc++;
      if (wb_cyc_o) cyc_cyc++;
      if (wb_stb_o) begin
        stb_cyc++;
        if (wb_adr_o != fetch_adr) begin
          data_phase++;
          data_sel = wb_sel_o; data_dat = wb_dat_o; data_we = wb_we_o;
        end
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic end_seq();
    d_req = 1'b0; i_req = 1'b0; d_we = 1'b0;
    step();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0) begin failures++; $display("FAIL rst_wb_ctl got=%b%b%b exp=000", wb_cyc_o, wb_stb_o, wb_we_o); end
    checks++; if (wb_adr_o !== 32'h0 || wb_sel_o !== 4'h0 || wb_dat_o !== 32'h0) begin failures++; $display("FAIL rst_wb_bus adr=%h sel=%b dat=%h exp=0", wb_adr_o, wb_sel_o, wb_dat_o); end
    checks++; if (d_rdata !== 32'h0 || i_rdata !== 32'h0 || d_err !== 1'b0 || i_err !== 1'b0) begin failures++; $display("FAIL rst_results d=%h i=%h de=%b ie=%b exp=0", d_rdata, i_rdata, d_err, i_err); end
    d_req = 1'b1;
    #1;
    checks++; if (stall_pipl !== 1'b1) begin failures++; $display("FAIL rst_stall_req got=%b exp=1", stall_pipl); end
    d_req = 1'b0;
    #1;
    reset_n = 1'b1;
    step();
    checks++; if (stall_pipl !== 1'b0 || wb_cyc_o !== 1'b0) begin failures++; $display("FAIL rst_idle stall=%b cyc=%b exp=0,0", stall_pipl, wb_cyc_o); end
  endtask

  task automatic test_word_load();
    load_dat = 32'hDEADBEEF;
    d_req = 1'b1; d_we = 1'b0; d_op = 3'b010; d_addr = 32'h100;
    i_req = 1'b1; i_addr = 32'h40;
    run_until_done(20);
    checks++; if (!done_seen) begin failures++; $display("FAIL lw_done got=none exp=DONE within 20"); end
    checks++; if (stall_cyc != 3) begin failures++; $display("FAIL lw_stall_cycles got=%0d exp=3", stall_cyc); end
    checks++; if (cyc_cyc != 2 || data_phase != 1) begin failures++; $display("FAIL lw_b2b cyc=%0d dphase=%0d exp=2,1", cyc_cyc, data_phase); end
    checks++; if (d_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_d_rdata got=%h exp=deadbeef", d_rdata); end
    checks++; if (i_rdata !== 32'h00000013 || i_err !== 1'b0 || d_err !== 1'b0) begin failures++; $display("FAIL lw_i_rdata got=%h ie=%b de=%b exp=00000013,0,0", i_rdata, i_err, d_err); end
    end_seq();
  endtask

  task automatic test_loads();
    logic [2:0]  ops [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] adrs[4] = '{32'h203, 32'h203, 32'h202, 32'h200};
    logic [31:0] exps[4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    logic [3:0]  sels[4] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011};
    load_dat = 32'h80FF7F01;
    for (int n = 0; n < 4; n++) begin
      d_req = 1'b1; d_we = 1'b0; d_op = ops[n]; d_addr = adrs[n];
      run_until_done(20);
      checks++; if (!done_seen || stall_cyc != 2) begin failures++; $display("FAIL load%0d_latency done=%b stall=%0d exp=1,2", n, done_seen, stall_cyc); end
      checks++; if (data_sel !== sels[n]) begin failures++; $display("FAIL load%0d_sel got=%b exp=%b", n, data_sel, sels[n]); end
      checks++; if (d_rdata !== exps[n]) begin failures++; $display("FAIL load%0d_rdata got=%h exp=%h", n, d_rdata, exps[n]); end
      end_seq();
    end
  endtask

  task automatic test_stores();
    logic [2:0]  ops [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] wds [3] = '{32'h123456AB, 32'h0000BEEF, 32'hCAFEF00D};
    logic [3:0]  sels[3] = '{4'b0100, 4'b1100, 4'b1111};
    logic [31:0] dats[3] = '{32'hABABABAB, 32'hBEEFBEEF, 32'hCAFEF00D};
    logic [31:0] adrs[3] = '{32'h302, 32'h302, 32'h300};
    for (int n = 0; n < 3; n++) begin
      d_req = 1'b1; d_we = 1'b1; d_op = ops[n]; d_addr = adrs[n]; d_wdata = wds[n];
      run_until_done(20);
      checks++; if (!done_seen || data_phase != 1) begin failures++; $display("FAIL store%0d_phase done=%b dphase=%0d exp=1,1", n, done_seen, data_phase); end
      checks++; if (data_sel !== sels[n] || data_we !== 1'b1) begin failures++; $display("FAIL store%0d_sel got=%b we=%b exp=%b,1", n, data_sel, data_we, sels[n]); end
      checks++; if (data_dat !== dats[n]) begin failures++; $display("FAIL store%0d_dat got=%h exp=%h", n, data_dat, dats[n]); end
      end_seq();
    end
  endtask

  task automatic test_misaligned();
    load_dat = 32'h11223344;
    d_req = 1'b1; d_we = 1'b0; d_op = 3'b010; d_addr = 32'h102;
    i_req = 1'b1; i_addr = 32'h40;
    run_until_done(20);
    checks++; if (!done_seen || stall_cyc != 2) begin failures++; $display("FAIL mis_latency done=%b stall=%0d exp=1,2", done_seen, stall_cyc); end
    checks++; if (data_phase != 0 || stb_cyc != 1) begin failures++; $display("FAIL mis_no_data dphase=%0d stb=%0d exp=0,1", data_phase, stb_cyc); end
    checks++; if (d_err !== 1'b1 || d_rdata !== 32'h0) begin failures++; $display("FAIL mis_d_result de=%b d=%h exp=1,0", d_err, d_rdata); end
    checks++; if (i_err !== 1'b0 || i_rdata !== 32'h00000013) begin failures++; $display("FAIL mis_fetch ie=%b i=%h exp=0,00000013", i_err, i_rdata); end
    end_seq();
  endtask

  task automatic test_bus_err();
    err_en = 1'b1; fetch_dat = 32'h00A00093;
    d_req = 1'b1; d_we = 1'b0; d_op = 3'b010; d_addr = 32'h100;
    i_req = 1'b1; i_addr = 32'h40;
    run_until_done(20);
    checks++; if (!done_seen || stall_cyc != 3) begin failures++; $display("FAIL berr_latency done=%b stall=%0d exp=1,3", done_seen, stall_cyc); end
    checks++; if (d_err !== 1'b1 || d_rdata !== 32'h0) begin failures++; $display("FAIL berr_d_result de=%b d=%h exp=1,0", d_err, d_rdata); end
    checks++; if (i_err !== 1'b0 || i_rdata !== 32'h00A00093) begin failures++; $display("FAIL berr_fetch ie=%b i=%h exp=0,00a00093", i_err, i_rdata); end
    end_seq();
    err_en = 1'b0;
    checks++; if (d_err !== 1'b0) begin failures++; $display("FAIL berr_clear de=%b exp=0", d_err); end
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    i_req = 1'b1; i_addr = 32'h40;
    run_until_done(30);
    checks++; if (!done_seen) begin failures++; $display("FAIL tmo_done got=none exp=DONE within 30"); end
    checks++; if (stb_cyc != 5 || stall_cyc != 6) begin failures++; $display("FAIL tmo_stb_cycles stb=%0d stall=%0d exp=5,6", stb_cyc, stall_cyc); end
    checks++; if (i_err !== 1'b1 || i_rdata !== 32'h0 || d_err !== 1'b0) begin failures++; $display("FAIL tmo_result ie=%b i=%h de=%b exp=1,0,0", i_err, i_rdata, d_err); end
    end_seq();
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    ack_en = 1'b0; load_dat = 32'h5A5A0F0F;
    d_req = 1'b1; d_we = 1'b0; d_op = 3'b010; d_addr = 32'h100;
    step();
    step();
    checks++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1) begin failures++; $display("FAIL rmid_in_data cyc=%b stb=%b exp=1,1", wb_cyc_o, wb_stb_o); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin failures++; $display("FAIL rmid_async_drop cyc=%b stb=%b exp=0,0", wb_cyc_o, wb_stb_o); end
    d_req = 1'b0; ack_en = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    checks++; if (stall_pipl !== 1'b0 || wb_cyc_o !== 1'b0 || d_rdata !== 32'h0) begin failures++; $display("FAIL rmid_idle stall=%b cyc=%b d=%h exp=0,0,0", stall_pipl, wb_cyc_o, d_rdata); end
    d_req = 1'b1; d_op = 3'b010; d_addr = 32'h100;
    run_until_done(20);
    checks++; if (!done_seen || stall_cyc != 2 || d_rdata !== 32'h5A5A0F0F) begin failures++; $display("FAIL rmid_recover done=%b stall=%0d d=%h exp=1,2,5a5a0f0f", done_seen, stall_cyc, d_rdata); end
    end_seq();
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_op = 3'b000;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    ack_en = 1'b1; err_en = 1'b0;
    fetch_adr = 32'h40; fetch_dat = 32'h00000013; load_dat = 32'h0;
    test_reset();
    test_word_load();
    test_loads();
    test_stores();
    test_misaligned();
    test_bus_err();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
